// File: rtl/rtl_settings_pkg.sv
// Shared enums and state helpers for the memory test sequencer.
// Optional watchdog build switch: MEM_TEST_WDOG_EN.
package rtl_settings_pkg;

  typedef enum logic [1:0] {
    READ_ONLY       = 2'd0,
    WRITE_ONLY      = 2'd1,
    WRITE_AND_CHECK = 2'd2,
    BURST_CHECK     = 2'd3
  } test_mode_t;

  typedef enum logic [3:0] {
    IDLE_S        = 4'd0,
    LOAD_S        = 4'd1,
    WRITE_ONLY_S  = 4'd2,
    READ_ONLY_S   = 4'd3,
    WRITE_WORD_S  = 4'd4,
    READ_WORD_S   = 4'd5,
    BURST_WR_S    = 4'd6,
    BURST_RD_S    = 4'd7,
    END_TEST_S    = 4'd8,
    ERROR_CHECK_S = 4'd9
  } state_t;

  localparam logic TYPE_WR = 1'b0;
  localparam logic TYPE_RD = 1'b1;

  // States that present a command to the transmitter.
  function automatic logic is_cmd(state_t s);
    return s inside {WRITE_ONLY_S, READ_ONLY_S,
                     WRITE_WORD_S, READ_WORD_S,
                     BURST_WR_S, BURST_RD_S};
  endfunction

  // States that wait for downstream to drain.
  function automatic logic is_wait(state_t s);
    return s inside {END_TEST_S, ERROR_CHECK_S};
  endfunction

  // Command states that issue reads.
  function automatic logic is_read(state_t s);
    return s inside {READ_ONLY_S, READ_WORD_S, BURST_RD_S};
  endfunction

  // Entry command state for a test mode.
  function automatic state_t first_state(test_mode_t m);
    state_t s;
    case (m)
      READ_ONLY:       s = READ_ONLY_S;
      WRITE_ONLY:      s = WRITE_ONLY_S;
      WRITE_AND_CHECK: s = WRITE_WORD_S;
      default:         s = BURST_WR_S;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/addr_replay_buf.sv
// Address replay FIFO: burst write addresses are stored and
// read back in the same order for the burst read phase.
module addr_replay_buf #(
  parameter int ADDR_W  = 28,
  parameter int DEPTH_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] rd_data,
  output logic [DEPTH_W:0]  count
);

  localparam int DEPTH = 2 ** DEPTH_W;

  logic [ADDR_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q;
  logic [DEPTH_W-1:0] rd_ptr_q;
  logic [DEPTH_W:0]   cnt_q;

  // Storage array, no reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (DEPTH_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (DEPTH_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: issues write/read command streams.
// Define MEM_TEST_WDOG_EN to bound the finish wait.
module mem_test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic               rst_i,
  input  logic               clk_i,
  input  logic               test_start_i,
  input  logic               test_abort_i,
  input  logic [1:0]         test_mode_i,
  input  logic [CNT_W-1:0]   test_count_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               stop_on_error_i,
  input  logic               cmp_error_i,
  input  logic               cmp_busy_i,
  input  logic               meas_busy_i,
  input  logic               trans_busy_i,
  input  logic               trans_ready_i,
  input  logic [ADDR_W-1:0]  next_addr_i,
  output logic               next_addr_en_o,
  output logic               trans_valid_o,
  output logic               trans_type_o,
  output logic [ADDR_W-1:0]  trans_addr_o,
  output logic               test_finished_o,
  output logic               test_result_o,
  output logic [CNT_W-1:0]   err_cnt_o
);

  state_t             state_q;
  state_t             state_n;
  test_mode_t         mode_q;
  logic               stop_q;
  logic [BURST_W:0]   burst_q;
  logic [BURST_W:0]   wr_cnt_q;
  logic [BURST_W:0]   wr_n;
  logic [CNT_W:0]     rem_q;
  logic               accept;
  logic               counted;
  logic               last;
  logic               burst_end;
  logic               set_fin;
  logic               set_res;
  logic               err_inc;
  logic               wr_clr;
  logic               wdog_hit;
  logic               fin_q;
  logic               res_q;
  logic [CNT_W-1:0]   err_q;
  logic [ADDR_W-1:0]  buf_rd;
  logic [BURST_W:0]   buf_cnt;

  assign trans_valid_o = is_cmd(state_q);
  assign trans_type_o  = is_read(state_q) ? TYPE_RD : TYPE_WR;
  assign trans_addr_o  = (state_q == BURST_RD_S) ? buf_rd
                                                  : next_addr_i;
  assign accept  = trans_valid_o && trans_ready_i;
  // Only-modes count everything, check modes count reads.
  assign counted = accept &&
                   ((mode_q inside {READ_ONLY, WRITE_ONLY}) ||
                    trans_type_o);
  assign last    = (rem_q == (CNT_W+1)'(1));
  assign wr_n    = wr_cnt_q + (BURST_W+1)'(1);
  assign burst_end = (wr_n == burst_q) ||
                     ((CNT_W+1)'(wr_n) == rem_q);

  assign next_addr_en_o =
    (state_q == LOAD_S) ||
    (accept && (state_q inside {WRITE_ONLY_S, READ_ONLY_S,
                                READ_WORD_S, BURST_WR_S}));

  addr_replay_buf #(
    .ADDR_W  (ADDR_W),
    .DEPTH_W (BURST_W)
  ) u_buf (
    .clk     (clk_i),
    .rst     (rst_i),
    .flush   (state_q == LOAD_S),
    .wr_en   (accept && (state_q == BURST_WR_S)),
    .wr_data (next_addr_i),
    .rd_en   (accept && (state_q == BURST_RD_S)),
    .rd_data (buf_rd),
    .count   (buf_cnt)
  );

`ifdef MEM_TEST_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  // Cycles spent waiting for downstream to go idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 wdog_q <= '0;
    else if (is_wait(state_q)) wdog_q <= wdog_q + WD_W'(1);
    else                       wdog_q <= '0;
  end

  assign wdog_hit = (wdog_q == WD_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE_S;
    else       state_q <= state_n;
  end

  // Next state plus finish/result/error decisions.
  always_comb begin
    state_n = state_q;
    set_fin = 1'b0;
    set_res = 1'b0;
    err_inc = 1'b0;
    wr_clr  = 1'b0;
    case (state_q)
      IDLE_S:
        if (test_start_i) state_n = LOAD_S;
      LOAD_S:
        state_n = first_state(test_mode_t'(test_mode_i));
      WRITE_ONLY_S, READ_ONLY_S:
        if (counted && last) state_n = END_TEST_S;
      WRITE_WORD_S:
        if (accept) state_n = READ_WORD_S;
      READ_WORD_S:
        if (accept) state_n = last ? END_TEST_S : WRITE_WORD_S;
      BURST_WR_S:
        if (accept && burst_end) state_n = BURST_RD_S;
      BURST_RD_S:
        if (accept) begin
          if (last) begin
            state_n = END_TEST_S;
          end else if (buf_cnt == (BURST_W+1)'(1)) begin
            state_n = BURST_WR_S;
            wr_clr  = 1'b1;
          end
        end
      END_TEST_S, ERROR_CHECK_S:
        if (!(cmp_busy_i || meas_busy_i || trans_busy_i)) begin
          set_fin = 1'b1;
          state_n = IDLE_S;
        end else if (wdog_hit) begin
          set_fin = 1'b1;
          set_res = 1'b1;
          state_n = IDLE_S;
        end
      default:
        state_n = IDLE_S;
    endcase
    if (cmp_error_i && (is_cmd(state_q) || is_wait(state_q))) begin
      set_res = 1'b1;
      if (!stop_q)               err_inc = 1'b1;
      else if (is_cmd(state_q))  state_n = ERROR_CHECK_S;
    end
    // Abort is applied last so it wins over a same-cycle error.
    if (test_abort_i) begin
      if (is_cmd(state_q) || state_q == LOAD_S) begin
        set_res = 1'b1;
        state_n = END_TEST_S;
      end else if (is_wait(state_q)) begin
        set_res = 1'b1;
      end
    end
  end

  // Test configuration latch and progress counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q   <= READ_ONLY;
      stop_q   <= 1'b0;
      burst_q  <= '0;
      rem_q    <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == LOAD_S) begin
      mode_q   <= test_mode_t'(test_mode_i);
      stop_q   <= stop_on_error_i;
      burst_q  <= {1'b0, burst_len_i} + (BURST_W+1)'(1);
      rem_q    <= {1'b0, test_count_i} + (CNT_W+1)'(1);
      wr_cnt_q <= '0;
    end else begin
      if (counted) rem_q <= rem_q - (CNT_W+1)'(1);
      if (wr_clr)
        wr_cnt_q <= '0;
      else if (accept && state_q == BURST_WR_S)
        wr_cnt_q <= wr_n;
    end
  end

  // Sticky status, cleared when a new test is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fin_q <= 1'b0;
      res_q <= 1'b0;
      err_q <= '0;
    end else if (state_q == IDLE_S && test_start_i) begin
      fin_q <= 1'b0;
      res_q <= 1'b0;
      err_q <= '0;
    end else begin
      if (set_fin) fin_q <= 1'b1;
      if (set_res) res_q <= 1'b1;
      if (err_inc && err_q != '1) err_q <= err_q + CNT_W'(1);
    end
  end

  assign test_finished_o = fin_q;
  assign test_result_o   = res_q;
  assign err_cnt_o       = err_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Scoreboard bench for mem_test_sequencer.
// Watchdog case runs only when MEM_TEST_WDOG_EN is defined.
module tb_mem_test_sequencer;
  import rtl_settings_pkg::*;

  localparam int ADDR_W  = 28;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 3;
  localparam int TAB     = 8192;
  localparam int LIMIT   = 5000;

  logic clk = 1'b0;
  logic rst;
  logic test_start, test_abort, stop_on_error;
  logic cmp_error, cmp_busy, meas_busy, trans_busy;
  logic trans_ready;
  logic [1:0]         test_mode;
  logic [CNT_W-1:0]   test_count;
  logic [BURST_W-1:0] burst_len;
  logic [ADDR_W-1:0]  next_addr;
  logic               next_addr_en, trans_valid, trans_type;
  logic [ADDR_W-1:0]  trans_addr;
  logic               test_finished, test_result;
  logic [CNT_W-1:0]   err_cnt;

  always #5 clk = ~clk;

  mem_test_sequencer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .BURST_W(BURST_W), .WDOG_CYCLES(16)
  ) dut (
    .rst_i(rst), .clk_i(clk),
    .test_start_i(test_start), .test_abort_i(test_abort),
    .test_mode_i(test_mode), .test_count_i(test_count),
    .burst_len_i(burst_len), .stop_on_error_i(stop_on_error),
    .cmp_error_i(cmp_error), .cmp_busy_i(cmp_busy),
    .meas_busy_i(meas_busy), .trans_busy_i(trans_busy),
    .trans_ready_i(trans_ready), .next_addr_i(next_addr),
    .next_addr_en_o(next_addr_en), .trans_valid_o(trans_valid),
    .trans_type_o(trans_type), .trans_addr_o(trans_addr),
    .test_finished_o(test_finished), .test_result_o(test_result),
    .err_cnt_o(err_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  int rd_seen = 0;
  int unsigned gen_idx = 0;
  logic [ADDR_W-1:0] addr_tab [TAB];
  logic [ADDR_W:0]   exp_q [$];

  // Address generator: advances one table entry per request.
  assign next_addr = addr_tab[gen_idx % TAB];
  always @(posedge clk) if (next_addr_en) gen_idx <= gen_idx + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] aof(input int unsigned i);
    return addr_tab[i % TAB];
  endfunction

  // Reference: command list derived directly from the mode rules.
  task automatic build_exp(input int mode, input int cnt,
                           input int blen, input int unsigned base);
    int n = cnt + 1;
    int unsigned idx = base + 1;
    int b = blen + 1;
    int rem;
    int m;
    case (mode)
      0: for (int k = 0; k < n; k++) exp_q.push_back({1'b1, aof(idx+k)});
      1: for (int k = 0; k < n; k++) exp_q.push_back({1'b0, aof(idx+k)});
      2: for (int k = 0; k < n; k++) begin
           exp_q.push_back({1'b0, aof(idx+k)});
           exp_q.push_back({1'b1, aof(idx+k)});
         end
      default: begin
        rem = n;
        while (rem > 0) begin
          m = (rem < b) ? rem : b;
          for (int j = 0; j < m; j++) exp_q.push_back({1'b0, aof(idx+j)});
          for (int j = 0; j < m; j++) exp_q.push_back({1'b1, aof(idx+j)});
          idx += m;
          rem -= m;
        end
      end
    endcase
  endtask

  // Monitor: pops expected commands on each accept.
  logic            stall_p = 1'b0;
  logic [ADDR_W:0] stall_v;
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p && trans_valid)
        check("hold_stable", {trans_type, trans_addr}, stall_v);
      if (trans_valid && trans_ready) begin
        if (trans_type) rd_seen++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_cmd: got %0h expected none",
                   {trans_type, trans_addr});
        end else begin
          check("cmd", {trans_type, trans_addr}, exp_q.pop_front());
        end
      end
      stall_p = trans_valid && !trans_ready;
      stall_v = {trans_type, trans_addr};
    end
  end

  // Ready driver: always, random, or stalled.
  initial begin
    trans_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       trans_ready = 1'b1;
        1:       trans_ready = 1'($urandom_range(0, 1));
        default: trans_ready = 1'b0;
      endcase
    end
  end

  task automatic start_test(input int mode, input int cnt,
                            input int blen, input bit stop);
    test_mode     = mode[1:0];
    test_count    = cnt[CNT_W-1:0];
    burst_len     = blen[BURST_W-1:0];
    stop_on_error = stop;
    cmp_busy = 1'b1; meas_busy = 1'b1; trans_busy = 1'b1;
    build_exp(mode, cnt, blen, gen_idx);
    test_start = 1'b1;
    tick;
    test_start = 1'b0;
    tick;
    test_mode     = 2'($urandom);
    test_count    = CNT_W'($urandom);
    burst_len     = BURST_W'($urandom);
    stop_on_error = 1'($urandom);
  endtask

  task automatic finish_test(input string name, input bit exp_res,
                             input int exp_err, input bit strict);
    int i = 0;
    while (i < LIMIT &&
           (trans_valid || (strict && exp_q.size() != 0))) begin
      tick;
      i++;
    end
    check({name, "_cmds_done"}, (i < LIMIT), 1);
    repeat (2) tick;
    cmp_busy = 1'b0; trans_busy = 1'b0;
    tick;
    check({name, "_fin_wait"}, test_finished, 0);
    meas_busy = 1'b0;
    tick;
    check({name, "_fin"}, test_finished, 1);
    check({name, "_res"}, test_result, exp_res);
    if (exp_err >= 0) check({name, "_err"}, err_cnt, exp_err);
    exp_q.delete();
    tick;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    int rd0;
    int i;
    bit bad;
    rst = 1'b1;
    test_start = 0; test_abort = 0; stop_on_error = 0;
    cmp_error = 0; cmp_busy = 0; meas_busy = 0; trans_busy = 0;
    test_mode = 0; test_count = 0; burst_len = 0;
    for (int k = 0; k < TAB; k++) addr_tab[k] = ADDR_W'($urandom);
    repeat (3) tick;
    check("rst_valid", trans_valid, 0);
    check("rst_en", next_addr_en, 0);
    check("rst_fin", test_finished, 0);
    check("rst_res", test_result, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b0;
    tick;

    rdy_mode = 0;
    start_test(1, 3, 0, 0);
    finish_test("wonly4", 0, 0, 1);

    rdy_mode = 1;
    start_test(3, 9, 3, 0);
    finish_test("burst10", 0, 0, 1);

    start_test(0, 0, 0, 0);
    finish_test("ronly1", 0, 0, 1);

    start_test(3, 20, 7, 0);
    finish_test("burst_max", 0, 0, 1);

    start_test(2, 4, 0, 0);
    repeat (3) tick;
    cmp_error = 1; tick; cmp_error = 0;
    repeat (2) tick;
    cmp_error = 1; tick; cmp_error = 0;
    finish_test("wac_err2", 1, 2, 1);

    rdy_mode = 0;
    rd0 = rd_seen;
    start_test(2, 9, 0, 1);
    i = 0;
    while (i < LIMIT && rd_seen != rd0 + 2) begin tick; i++; end
    check("stop_rd2_seen", (i < LIMIT), 1);
    cmp_error = 1; tick; cmp_error = 0;
    check("stop_valid_low", trans_valid, 0);
    finish_test("stop_err", 1, -1, 0);

    rdy_mode = 2;
    start_test(1, 5, 0, 0);
    repeat (3) tick;
    check("abort_stall_valid", trans_valid, 1);
    test_abort = 1; tick; test_abort = 0;
    check("abort_valid_low", trans_valid, 0);
    finish_test("abort", 1, -1, 0);

    start_test(2, 5, 0, 1);
    tick;
    test_abort = 1; cmp_error = 1;
    tick;
    test_abort = 0; cmp_error = 0;
    check("abort_err_valid_low", trans_valid, 0);
    finish_test("abort_err", 1, -1, 0);

    rdy_mode = 0;
    start_test(1, 255, 0, 0);
    cmp_error = 1;
    i = 0;
    while (i < LIMIT && trans_valid) begin tick; i++; end
    repeat (4) tick;
    cmp_error = 0;
    finish_test("full_cnt_sat", 1, 255, 1);

    rdy_mode = 1;
    start_test(3, 30, 2, 0);
    repeat (4) tick;
    rst = 1'b1;
    tick;
    check("midrst_valid", trans_valid, 0);
    check("midrst_fin", test_finished, 0);
    check("midrst_res", test_result, 0);
    check("midrst_err", err_cnt, 0);
    rst = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (trans_valid || test_finished) bad = 1;
    end
    check("midrst_quiet", bad, 0);
    cmp_busy = 0; meas_busy = 0; trans_busy = 0;
    tick;

    for (int t = 0; t < 10; t++) begin
      start_test($urandom_range(0, 3), $urandom_range(0, 20),
                 $urandom_range(0, 7), 1'($urandom));
      finish_test($sformatf("rand%0d", t), 0, 0, 1);
    end

`ifdef MEM_TEST_WDOG_EN
    rdy_mode = 0;
    start_test(1, 0, 0, 0);
    i = 0;
    while (i < LIMIT && trans_valid) begin tick; i++; end
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      tick;
      if (test_finished) bad = 1;
    end
    check("wdog_early", bad, 0);
    tick;
    check("wdog_fin", test_finished, 1);
    check("wdog_res", test_result, 1);
    cmp_busy = 0; meas_busy = 0; trans_busy = 0;
    exp_q.delete();
    tick;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
